// File: rtl/op_ctrl_mc.sv
// op_ctrl_mc: multi-channel add/subtract controller.
// Round-robin arbitration over per-channel start bits, operand capture at grant,
// EXEC_CYCLES of execute, then a one-cycle write-back strobe tagged with the
// channel index together with a one-hot start-bit clear back to the register bank.
module op_ctrl_mc #(
    parameter int  NCH         = 4,
    parameter int  DW          = 32,
    parameter int  EXEC_CYCLES = 1,
    localparam int CW          = $clog2(NCH)
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic [NCH-1:0]    i_start,
    input  logic [NCH*DW-1:0] i_op_a,
    input  logic [NCH*DW-1:0] i_op_b,
    input  logic [NCH-1:0]    i_mode,
    output logic [NCH-1:0]    o_busy,
    output logic              o_any_busy,
    output logic [DW-1:0]     o_result,
    output logic              o_carry,
    output logic              o_ovf,
    output logic              o_wr_en,
    output logic [CW-1:0]     o_wr_ch,
    output logic [NCH-1:0]    o_rst_start
);

    localparam int CNTW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_ptr, r_ch;
    logic [DW-1:0]   r_a, r_b;
    logic            r_mode;
    logic [CNTW-1:0] r_cnt;
    logic [NCH-1:0]  r_busy, r_rst_start;
    logic            r_any_busy, r_wr_en, r_carry, r_ovf;
    logic [DW-1:0]   r_result;
    logic [CW-1:0]   r_wr_ch;

    logic            w_gnt_vld;
    logic [CW-1:0]   w_gnt_ch;
    logic [NCH-1:0]  w_gnt_oh;
    logic [CW-1:0]   w_ptr_nxt;
    logic [DW-1:0]   w_b_eff;
    logic [DW:0]     w_sum;
    logic            w_ovf;

    // Round-robin pick: scan downward so the smallest offset from r_ptr wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_start[(int'(r_ptr) + i) % NCH]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = CW'((int'(r_ptr) + i) % NCH);
            end
        end
    end

    assign w_gnt_oh  = NCH'(1) << w_gnt_ch;
    assign w_ptr_nxt = (r_ch == CW'(NCH - 1)) ? '0 : r_ch + 1'b1;

    // Subtract is A + ~B + 1, so carry-out means "no borrow".
    assign w_b_eff = r_mode ? ~r_b : r_b;
    assign w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {{DW{1'b0}}, r_mode};
    assign w_ovf   = (r_a[DW-1] == w_b_eff[DW-1]) && (w_sum[DW-1] != r_a[DW-1]);

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARST) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state decode: IDLE -> EXEC on grant, EXEC -> WRITE on last cycle, WRITE lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_vld) w_state_nxt = EXEC;
            EXEC:    if (r_cnt == '0) w_state_nxt = WRITE;
            WRITE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, execute countdown and registered outputs; reset drops any in-flight op.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_ptr       <= '0;
            r_ch        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_mode      <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= '0;
            r_any_busy  <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_ch     <= '0;
            r_rst_start <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wr_en     <= 1'b0;
                    r_rst_start <= '0;
                    if (w_gnt_vld) begin
                        r_ch       <= w_gnt_ch;
                        r_a        <= i_op_a[int'(w_gnt_ch)*DW +: DW];
                        r_b        <= i_op_b[int'(w_gnt_ch)*DW +: DW];
                        r_mode     <= i_mode[w_gnt_ch];
                        r_cnt      <= CNTW'(EXEC_CYCLES - 1);
                        r_busy     <= w_gnt_oh;
                        r_any_busy <= 1'b1;
                    end
                end
                EXEC: begin
                    if (r_cnt == '0) begin
                        r_result    <= w_sum[DW-1:0];
                        r_carry     <= w_sum[DW];
                        r_ovf       <= w_ovf;
                        r_wr_en     <= 1'b1;
                        r_wr_ch     <= r_ch;
                        r_rst_start <= r_busy;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WRITE: begin
                    r_wr_en     <= 1'b0;
                    r_rst_start <= '0;
                    r_busy      <= '0;
                    r_any_busy  <= 1'b0;
                    r_ptr       <= w_ptr_nxt;
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_any_busy  = r_any_busy;
    assign o_result    = r_result;
    assign o_carry     = r_carry;
    assign o_ovf       = r_ovf;
    assign o_wr_en     = r_wr_en;
    assign o_wr_ch     = r_wr_ch;
    assign o_rst_start = r_rst_start;

endmodule

// File: tb/tb_op_ctrl_mc.sv
// Directed bench for op_ctrl_mc: one instance with EXEC_CYCLES=1, one with EXEC_CYCLES=3.
// Each instance has its own start-bit bank model; operands, modes and reset are shared.
module tb_op_ctrl_mc;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int CW  = 2;

    logic              ACLK = 1'b0;
    logic              ARST;
    logic [NCH-1:0]    st1, st3;
    logic [NCH*DW-1:0] op_a, op_b;
    logic [NCH-1:0]    mode;

    logic [NCH-1:0] busy1, rst1, busy3, rst3;
    logic           anyb1, carry1, ovf1, wr1, anyb3, carry3, ovf3, wr3;
    logic [DW-1:0]  res1, res3;
    logic [CW-1:0]  ch1, ch3;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 ACLK = ~ACLK;

    op_ctrl_mc #(.NCH(NCH), .DW(DW), .EXEC_CYCLES(1)) dut1 (
        .ACLK(ACLK), .ARST(ARST), .i_start(st1), .i_op_a(op_a), .i_op_b(op_b), .i_mode(mode),
        .o_busy(busy1), .o_any_busy(anyb1), .o_result(res1), .o_carry(carry1), .o_ovf(ovf1),
        .o_wr_en(wr1), .o_wr_ch(ch1), .o_rst_start(rst1)
    );

    op_ctrl_mc #(.NCH(NCH), .DW(DW), .EXEC_CYCLES(3)) dut3 (
        .ACLK(ACLK), .ARST(ARST), .i_start(st3), .i_op_a(op_a), .i_op_b(op_b), .i_mode(mode),
        .o_busy(busy3), .o_any_busy(anyb3), .o_result(res3), .o_carry(carry3), .o_ovf(ovf3),
        .o_wr_en(wr3), .o_wr_ch(ch3), .o_rst_start(rst3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: bank clears start bits flagged at the edge, then sample point at negedge.
    task automatic cyc();
        logic [NCH-1:0] c1, c3;
        c1 = rst1;
        c3 = rst3;
        @(posedge ACLK);
        #1;
        st1 = st1 & ~c1;
        st3 = st3 & ~c3;
        @(negedge ACLK);
    endtask

    task automatic setop(input int ch, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic m);
        op_a[ch*DW +: DW] = a;
        op_b[ch*DW +: DW] = b;
        mode[ch]          = m;
    endtask

    initial begin
        ARST = 1'b1;
        st1  = '0;
        st3  = '0;
        op_a = '0;
        op_b = '0;
        mode = '0;
        cyc();
        cyc();
        chk("rst_outs1", 64'({busy1, anyb1, res1, carry1, ovf1, wr1, ch1, rst1}), 64'(0));
        chk("rst_outs3", 64'({busy3, anyb3, res3, carry3, ovf3, wr3, ch3, rst3}), 64'(0));
        ARST = 1'b0;

        // ch0 add 5+3 on the single-cycle instance
        setop(0, 32'h5, 32'h3, 1'b0);
        st1 = 4'b0001;
        cyc();
        chk("t1_busy_exec", 64'(busy1), 64'(4'b0001));
        chk("t1_wr_exec", 64'(wr1), 64'(0));
        cyc();
        chk("t1_wr", 64'({wr1, ch1, rst1, busy1, anyb1}), 64'({1'b1, 2'd0, 4'b0001, 4'b0001, 1'b1}));
        chk("t1_res", 64'({res1, carry1, ovf1}), 64'({32'h8, 1'b0, 1'b0}));
        cyc();
        chk("t1_idle", 64'({wr1, rst1, busy1, anyb1, st1}), 64'(0));
        chk("t1_hold", 64'(res1), 64'(32'h8));

        // ch1 sub 3-5 (borrow)
        setop(1, 32'h3, 32'h5, 1'b1);
        st1 = 4'b0010;
        cyc();
        cyc();
        chk("t2_sub", 64'({wr1, ch1, rst1, res1, carry1, ovf1}),
            64'({1'b1, 2'd1, 4'b0010, 32'hFFFF_FFFE, 1'b0, 1'b0}));
        cyc();

        // ch1 add FFFFFFFF+1 (carry); ptr is 2 so this also wraps the scan
        setop(1, 32'hFFFF_FFFF, 32'h1, 1'b0);
        st1 = 4'b0010;
        cyc();
        cyc();
        chk("t3_carry", 64'({wr1, ch1, res1, carry1, ovf1}), 64'({1'b1, 2'd1, 32'h0, 1'b1, 1'b0}));
        cyc();

        // ch1 add 7FFFFFFF+1 (signed overflow)
        setop(1, 32'h7FFF_FFFF, 32'h1, 1'b0);
        st1 = 4'b0010;
        cyc();
        cyc();
        chk("t4_ovf", 64'({wr1, res1, carry1, ovf1}), 64'({1'b1, 32'h8000_0000, 1'b0, 1'b1}));
        cyc();

        // reset pulse brings ptr back to 0
        ARST = 1'b1;
        cyc();
        ARST = 1'b0;
        chk("rst2_outs1", 64'({busy1, res1, carry1, ovf1, wr1, ch1, rst1}), 64'(0));

        // simultaneous starts 1011 -> ch0, ch1, ch3
        setop(0, 32'h1, 32'h1, 1'b0);
        setop(1, 32'hA, 32'h4, 1'b1);
        setop(3, 32'h8000_0000, 32'h8000_0000, 1'b0);
        st1 = 4'b1011;
        cyc();
        chk("rr_busy0", 64'(busy1), 64'(4'b0001));
        cyc();
        chk("rr_wb0", 64'({wr1, ch1, rst1, res1}), 64'({1'b1, 2'd0, 4'b0001, 32'h2}));
        cyc();
        chk("rr_gap0", 64'({wr1, st1}), 64'({1'b0, 4'b1010}));
        cyc();
        chk("rr_busy1", 64'(busy1), 64'(4'b0010));
        cyc();
        chk("rr_wb1", 64'({wr1, ch1, rst1, res1, carry1}), 64'({1'b1, 2'd1, 4'b0010, 32'h6, 1'b1}));
        cyc();
        cyc();
        cyc();
        chk("rr_wb3", 64'({wr1, ch1, rst1, res1, carry1, ovf1}),
            64'({1'b1, 2'd3, 4'b1000, 32'h0, 1'b1, 1'b1}));
        cyc();
        chk("rr_done", 64'({wr1, busy1, st1}), 64'(0));

        // fairness: ch0 re-requests right after its clear while ch2 waits; ptr is 0
        setop(0, 32'h10, 32'h20, 1'b0);
        setop(2, 32'd100, 32'd1, 1'b1);
        st1 = 4'b0101;
        cyc();
        cyc();
        chk("fair_wb0", 64'({wr1, ch1, res1}), 64'({1'b1, 2'd0, 32'h30}));
        cyc();
        st1 = st1 | 4'b0001;
        cyc();
        chk("fair_busy2", 64'(busy1), 64'(4'b0100));
        cyc();
        chk("fair_wb2", 64'({wr1, ch1, rst1, res1, carry1}), 64'({1'b1, 2'd2, 4'b0100, 32'd99, 1'b1}));
        cyc();
        cyc();
        cyc();
        chk("fair_wb0b", 64'({wr1, ch1, rst1, res1}), 64'({1'b1, 2'd0, 4'b0001, 32'h30}));
        cyc();

        // reset mid-EXEC on the three-cycle instance
        setop(0, 32'd20, 32'd7, 1'b1);
        st3 = 4'b0001;
        cyc();
        chk("ar_busy", 64'({busy3, anyb3}), 64'({4'b0001, 1'b1}));
        cyc();
        chk("ar_exec", 64'(wr3), 64'(0));
        ARST = 1'b1;
        cyc();
        ARST = 1'b0;
        chk("ar_zero", 64'({busy3, anyb3, res3, carry3, ovf3, wr3, ch3, rst3}), 64'(0));
        chk("ar_start_kept", 64'(st3), 64'(4'b0001));
        cyc();
        cyc();
        cyc();
        chk("ar_rerun_wait", 64'({wr3, busy3}), 64'({1'b0, 4'b0001}));
        cyc();
        chk("ar_rerun_wb", 64'({wr3, ch3, rst3, res3, carry3}), 64'({1'b1, 2'd0, 4'b0001, 32'd13, 1'b1}));
        cyc();

        // operands change after grant; ch3 starts during EXEC and must not be lost
        setop(1, 32'd50, 32'd8, 1'b0);
        setop(3, 32'h8000_0000, 32'h8000_0000, 1'b0);
        st3 = 4'b0010;
        cyc();
        setop(1, 32'd1000, 32'd1000, 1'b1);
        st3 = st3 | 4'b1000;
        cyc();
        cyc();
        cyc();
        chk("cap_wb1", 64'({wr3, ch3, res3, carry3, ovf3}), 64'({1'b1, 2'd1, 32'd58, 1'b0, 1'b0}));
        cyc();
        chk("cap_hold", 64'({wr3, res3, st3}), 64'({1'b0, 32'd58, 4'b1000}));
        cyc();
        chk("late_busy3", 64'(busy3), 64'(4'b1000));
        cyc();
        cyc();
        cyc();
        chk("late_wb3", 64'({wr3, ch3, rst3, res3, carry3, ovf3}),
            64'({1'b1, 2'd3, 4'b1000, 32'h0, 1'b1, 1'b1}));
        cyc();
        chk("late_done", 64'({wr3, busy3, anyb3, st3}), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
